alu_ex_stage: RTL and testbench

Execute stage of the pipelined core. It accepts decoded operands from the issue stage over a valid/ready handshake and instantiates the existing 32-bit alu combinationally on the incoming operands. It registers the ALU result, flags, branch decision and overflow exception into a two-entry elastic buffer (main + skid) that drives the writeback stage. It provides 1-cycle latency, full throughput, and backpressure without a combinational ready path.

---
 rtl/alu_ex_stage.sv | 198 +++++++++++++++++++
 tb/tb_alu_ex_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ex_stage.sv
// Execute stage: combinational 32-bit ALU feeding a two-entry (main + skid) elastic
// buffer toward writeback, giving 1-cycle latency, full throughput and a registered in_ready.

module alu (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  ALUop,
    output logic [31:0] Result,
    output logic        Zero,
    output logic        CarryOut,
    output logic        Overflow
);
    logic [32:0] sum_s;
    logic [32:0] diff_s;
    logic        add_ov_s;
    logic        sub_ov_s;

    // Shared adder paths; subtraction is A + ~B + 1 so CarryOut there means "no borrow".
    always_comb begin
        sum_s    = {1'b0, A} + {1'b0, B};
        diff_s   = {1'b0, A} + {1'b0, ~B} + 33'd1;
        add_ov_s = (A[31] == B[31]) && (sum_s[31] != A[31]);
        sub_ov_s = (A[31] != B[31]) && (diff_s[31] != A[31]);
    end

    // Opcode decode.
    always_comb begin
        Result   = 32'd0;
        CarryOut = 1'b0;
        Overflow = 1'b0;
        case (ALUop)
            3'b000: Result = A & B;
            3'b001: Result = A | B;
            3'b010: begin
                Result   = sum_s[31:0];
                CarryOut = sum_s[32];
                Overflow = add_ov_s;
            end
            3'b011: begin
                Result   = {31'd0, ~diff_s[32]};
                CarryOut = diff_s[32];
            end
            3'b100: Result = A ^ B;
            3'b101: Result = ~(A | B);
            3'b110: begin
                Result   = diff_s[31:0];
                CarryOut = diff_s[32];
                Overflow = sub_ov_s;
            end
            3'b111: begin
                Result   = {31'd0, diff_s[31] ^ sub_ov_s};
                CarryOut = diff_s[32];
            end
            default: Result = 32'd0;
        endcase
        Zero = (Result == 32'd0);
    end
endmodule

module alu_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_A,
    input  logic [DATA_WIDTH-1:0] in_B,
    input  logic [2:0]            in_ALUop,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wen,
    input  logic [1:0]            in_br_type,
    input  logic                  in_ov_trap,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_wen,
    output logic                  out_zero,
    output logic                  out_carry,
    output logic                  out_overflow,
    output logic                  out_br_taken,
    output logic                  out_exc
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wen;
        logic                  zero;
        logic                  carry;
        logic                  overflow;
        logic                  br_taken;
        logic                  exc;
    } payload_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} buf_state_t;

    buf_state_t state_r;
    payload_t   main_r;
    payload_t   skid_r;
    payload_t   comp_s;
    logic       out_valid_r;
    logic       in_ready_r;
    logic       in_fire_s;
    logic       out_fire_s;
    logic [31:0] alu_res_s;
    logic        alu_zero_s;
    logic        alu_carry_s;
    logic        alu_ov_s;

    alu u_alu (
        .A        (in_A),
        .B        (in_B),
        .ALUop    (in_ALUop),
        .Result   (alu_res_s),
        .Zero     (alu_zero_s),
        .CarryOut (alu_carry_s),
        .Overflow (alu_ov_s)
    );

    // Payload that would be captured this cycle; br_type 11 falls through as "no branch".
    always_comb begin
        comp_s          = '0;
        comp_s.result   = alu_res_s;
        comp_s.rd       = in_rd;
        comp_s.zero     = alu_zero_s;
        comp_s.carry    = alu_carry_s;
        comp_s.overflow = alu_ov_s;
        comp_s.br_taken = ((in_br_type == 2'b01) && alu_zero_s) ||
                          ((in_br_type == 2'b10) && !alu_zero_s);
        comp_s.exc      = in_ov_trap && alu_ov_s;
        comp_s.wen      = in_wen && !(in_ov_trap && alu_ov_s);
        in_fire_s       = in_valid && in_ready_r;
        out_fire_s      = out_valid_r && out_ready;
    end

    // Elastic buffer control and storage; in_ready/out_valid are registered with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= EMPTY;
            main_r      <= '0;
            skid_r      <= '0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else if (flush) begin
            state_r     <= EMPTY;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        main_r      <= comp_s;
                        state_r     <= ONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_r <= comp_s;
                    end else if (in_fire_s) begin
                        skid_r     <= comp_s;
                        state_r    <= FULL;
                        in_ready_r <= 1'b0;
                    end else if (out_fire_s) begin
                        state_r     <= EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        main_r     <= skid_r;
                        state_r    <= ONE;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= EMPTY;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign out_valid    = out_valid_r;
    assign out_result   = main_r.result;
    assign out_rd       = main_r.rd;
    assign out_wen      = main_r.wen;
    assign out_zero     = main_r.zero;
    assign out_carry    = main_r.carry;
    assign out_overflow = main_r.overflow;
    assign out_br_taken = main_r.br_taken;
    assign out_exc      = main_r.exc;
endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed-vector bench for alu_ex_stage: streaming, backpressure, branch, overflow trap,
// flush and asynchronous reset, with hand-computed expected values.

module tb_alu_ex_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_A;
    logic [31:0] in_B;
    logic [2:0]  in_ALUop;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [1:0]  in_br_type;
    logic        in_ov_trap;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_zero;
    logic        out_carry;
    logic        out_overflow;
    logic        out_br_taken;
    logic        out_exc;

    int checks_cnt = 0;
    int errors_cnt = 0;

    alu_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_A         (in_A),
        .in_B         (in_B),
        .in_ALUop     (in_ALUop),
        .in_rd        (in_rd),
        .in_wen       (in_wen),
        .in_br_type   (in_br_type),
        .in_ov_trap   (in_ov_trap),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_rd       (out_rd),
        .out_wen      (out_wen),
        .out_zero     (out_zero),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_br_taken (out_br_taken),
        .out_exc      (out_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [4:0] rd, input logic wen, input logic [1:0] br,
                          input logic trap);
        in_valid   = 1'b1;
        in_A       = a;
        in_B       = b;
        in_ALUop   = op;
        in_rd      = rd;
        in_wen     = wen;
        in_br_type = br;
        in_ov_trap = trap;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] stream_a   [4] = '{32'd5, 32'd100, 32'd40, 32'd0};
    logic [31:0] stream_b   [4] = '{32'd7, 32'd23, 32'd2, 32'd0};
    logic [31:0] stream_exp [4] = '{32'd12, 32'd123, 32'd42, 32'd0};

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_A = 32'd0; in_B = 32'd0; in_ALUop = 3'd0;
        in_rd = 5'd0; in_wen = 1'b0; in_br_type = 2'd0; in_ov_trap = 1'b0;
        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_result", out_result, 32'd0);
        rst = 1'b0;
        step();

        // Back-to-back adds with out_ready high: one output per cycle, no bubbles.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(stream_a[i], stream_b[i], 3'b010, 5'd3 + 5'(i), 1'b1, 2'b00, 1'b0);
            step();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_result", out_result, stream_exp[i]);
            check("stream_rd", {27'd0, out_rd}, 32'd3 + 32'(i));
            check("stream_wen", {31'd0, out_wen}, 32'd1);
            check("stream_zero", {31'd0, out_zero}, (i == 3) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain", {31'd0, out_valid}, 32'd0);

        // Backpressure: two accepted, third held until the buffer drains.
        out_ready = 1'b0;
        set_op(32'd1, 32'd1, 3'b010, 5'd1, 1'b1, 2'b00, 1'b0);
        step();
        check("bp_ready1", {31'd0, in_ready}, 32'd1);
        set_op(32'd9, 32'd4, 3'b110, 5'd2, 1'b1, 2'b00, 1'b0);
        step();
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        check("bp_res_a", out_result, 32'd2);
        set_op(32'hFFFF_FFFF, 32'd2, 3'b111, 5'd4, 1'b1, 2'b00, 1'b0);
        step();
        check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_res", out_result, 32'd2);
        check("bp_hold_rd", {27'd0, out_rd}, 32'd1);
        out_ready = 1'b1;
        step();
        check("bp_res_b", out_result, 32'd5);
        check("bp_rd_b", {27'd0, out_rd}, 32'd2);
        check("bp_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_res_c", out_result, 32'd1);
        check("bp_rd_c", {27'd0, out_rd}, 32'd4);
        in_valid = 1'b0;
        step();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Branch decisions on a subtract.
        set_op(32'h10, 32'h10, 3'b110, 5'd0, 1'b0, 2'b01, 1'b0);
        step();
        check("beq_zero", {31'd0, out_zero}, 32'd1);
        check("beq_taken", {31'd0, out_br_taken}, 32'd1);
        set_op(32'h10, 32'h10, 3'b110, 5'd0, 1'b0, 2'b10, 1'b0);
        step();
        check("bne_eq_taken", {31'd0, out_br_taken}, 32'd0);
        set_op(32'h10, 32'h11, 3'b110, 5'd0, 1'b0, 2'b10, 1'b0);
        step();
        check("bne_ne_taken", {31'd0, out_br_taken}, 32'd1);
        check("bne_ne_zero", {31'd0, out_zero}, 32'd0);
        set_op(32'h10, 32'h10, 3'b110, 5'd0, 1'b0, 2'b11, 1'b0);
        step();
        check("br_reserved", {31'd0, out_br_taken}, 32'd0);

        // Signed overflow with and without trap.
        set_op(32'h7FFF_FFFF, 32'd1, 3'b010, 5'd7, 1'b1, 2'b00, 1'b1);
        step();
        check("ov_result", out_result, 32'h8000_0000);
        check("ov_flag", {31'd0, out_overflow}, 32'd1);
        check("ov_exc", {31'd0, out_exc}, 32'd1);
        check("ov_wen", {31'd0, out_wen}, 32'd0);
        set_op(32'h7FFF_FFFF, 32'd1, 3'b010, 5'd7, 1'b1, 2'b00, 1'b0);
        step();
        check("notrap_exc", {31'd0, out_exc}, 32'd0);
        check("notrap_wen", {31'd0, out_wen}, 32'd1);
        in_valid = 1'b0;
        step();

        // Flush a full buffer while a new op is presented.
        out_ready = 1'b0;
        set_op(32'd1, 32'd2, 3'b010, 5'd5, 1'b1, 2'b00, 1'b0);
        step();
        set_op(32'd3, 32'd4, 3'b010, 5'd6, 1'b1, 2'b00, 1'b0);
        step();
        check("fl_pre_ready", {31'd0, in_ready}, 32'd0);
        set_op(32'd100, 32'd100, 3'b010, 5'd9, 1'b1, 2'b00, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", {31'd0, out_valid}, 32'd0);
        check("fl_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        check("fl_no_ghost", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset mid-cycle with a full buffer.
        out_ready = 1'b0;
        set_op(32'd1, 32'd2, 3'b010, 5'd5, 1'b1, 2'b00, 1'b0);
        step();
        set_op(32'd3, 32'd4, 3'b010, 5'd6, 1'b1, 2'b00, 1'b0);
        step();
        in_valid = 1'b0;
        check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", {31'd0, out_valid}, 32'd0);
        check("ar_result", out_result, 32'd0);
        check("ar_rd", {27'd0, out_rd}, 32'd0);
        check("ar_wen", {31'd0, out_wen}, 32'd0);
        check("ar_ready", {31'd0, in_ready}, 32'd1);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        set_op(32'hF0, 32'hFF, 3'b100, 5'd8, 1'b1, 2'b00, 1'b0);
        step();
        check("ar_xor_valid", {31'd0, out_valid}, 32'd1);
        check("ar_xor_result", out_result, 32'h0F);
        in_valid = 1'b0;
        step();
        check("ar_final_empty", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
